// File: rtl/dtable_tracker_pkg.sv
// Shared constants, CTRL bit positions and FSM encoding for the D-table writer.
package dtable_tracker_pkg;

    localparam logic [15:0] DMEM_BASE_DEF    = 16'h0200;
    localparam logic [15:0] DMEM_SIZE_DEF    = 16'h0800;
    localparam int          BLK_SIZE_DEF     = 128;
    localparam logic [14:0] CTRL_ADDR_DEF    = 15'h0190;
    // Byte address where the read-only D-table memory is mapped for software.
    localparam logic [15:0] DTABLE_BASE_ADDR = 16'h01A0;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;
    localparam int CTRL_BUSY_BIT   = 15;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } dt_state_e;

endpackage

// File: rtl/dtable_popcnt16.sv
// Combinational population count of a 16-bit word.
module dtable_popcnt16 (
    input  logic [15:0] din,
    output logic [4:0]  ones
);

    always_comb begin
        ones = '0;
        for (int i = 0; i < 16; i++) begin
            ones = ones + 5'(din[i]);
        end
    end

endmodule

// File: rtl/dtable_tracker.sv
// Dirty-block table writer: snoops DMEM writes into a bitmap, CTRL register and clear sweep.
// Optional COUNT register (popcount of the bitmap) when DTRACK_POPCNT_EN is defined.
module dtable_tracker
    import dtable_tracker_pkg::*;
#(
    parameter logic [15:0] DMEM_BASE    = DMEM_BASE_DEF,
    parameter logic [15:0] DMEM_SIZE    = DMEM_SIZE_DEF,
    parameter int          BLK_SIZE     = BLK_SIZE_DEF,
    parameter logic [14:0] CTRL_ADDR    = CTRL_ADDR_DEF,
    localparam int         BLK_MSB      = $clog2(BLK_SIZE),
    localparam int         TOTAL_BLOCKS = int'(DMEM_SIZE) >> BLK_MSB
) (
    input  logic                    mclk,
    input  logic                    puc_rst,
    input  logic [13:0]             per_addr,
    input  logic [15:0]             per_din,
    input  logic                    per_en,
    input  logic [1:0]              per_we,
    output logic [15:0]             per_dout,
    input  logic [15:0]             mem_addr,
    input  logic [1:0]              mem_wr,
    output logic [TOTAL_BLOCKS-1:0] dtable_out
);

    localparam int          NWORDS     = (TOTAL_BLOCKS + 15) / 16;
    localparam int          IDX_W      = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [16:0] DMEM_LAST  = {1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE} - 17'd1;
    localparam logic [13:0] CTRL_WADDR = CTRL_ADDR[14:1];

    dt_state_e               state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    enable_q;
    logic [TOTAL_BLOCKS-1:0] dtable_q, set_vec, clr_vec;
    logic [15:0]             blk_off, blk_idx, ctrl_rd, cnt_rd;
    logic                    trk_hit, sel_ctrl, ctrl_wr, clr_start;
    logic                    unused_din;

    assign unused_din = ^per_din[15:2];

    // Tracking decode; the 17-bit upper bound keeps DMEM ending at 0xFFFF legal.
    assign blk_off = mem_addr - DMEM_BASE;
    assign blk_idx = blk_off >> BLK_MSB;
    assign trk_hit = enable_q && (|mem_wr) && (mem_addr >= DMEM_BASE)
                     && ({1'b0, mem_addr} <= DMEM_LAST);

    always_comb begin
        for (int k = 0; k < TOTAL_BLOCKS; k++) begin
            set_vec[k] = trk_hit && (blk_idx == 16'(k));
            clr_vec[k] = (state_q == ST_SWEEP) && (idx_q == IDX_W'(k / 16));
        end
    end

    assign sel_ctrl  = per_en && (per_addr == CTRL_WADDR);
    assign ctrl_wr   = sel_ctrl && (|per_we);
    assign clr_start = ctrl_wr && per_din[CTRL_CLEAR_BIT];

    always_comb begin
        ctrl_rd                  = '0;
        ctrl_rd[CTRL_ENABLE_BIT] = enable_q;
        ctrl_rd[CTRL_BUSY_BIT]   = (state_q == ST_SWEEP);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (clr_start) begin
                    idx_d = '0;
                end else if (idx_q == IDX_W'(NWORDS - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Set is OR-ed after the clear mask so a write racing the sweep survives.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            enable_q <= 1'b0;
            dtable_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            if (ctrl_wr) enable_q <= per_din[CTRL_ENABLE_BIT];
            dtable_q <= (dtable_q & ~clr_vec) | set_vec;
        end
    end

`ifdef DTRACK_POPCNT_EN
    localparam int CNT_W = $clog2(TOTAL_BLOCKS + 1);

    logic [NWORDS*16-1:0] swept_pad;
    logic [15:0]          swept_word;
    logic [4:0]           swept_ones;
    logic                 cnt_inc, sel_cnt;
    logic [CNT_W-1:0]     count_q;

    // Bits about to be cleared, excluding those re-set in the same cycle.
    assign swept_pad  = (NWORDS*16)'(dtable_q & ~set_vec);
    assign swept_word = (state_q == ST_SWEEP) ? swept_pad[16*idx_q +: 16] : '0;
    assign cnt_inc    = |(set_vec & ~dtable_q);

    dtable_popcnt16 u_popcnt (
        .din  (swept_word),
        .ones (swept_ones)
    );

    always_ff @(posedge mclk) begin
        if (puc_rst) count_q <= '0;
        else         count_q <= count_q + CNT_W'(cnt_inc) - CNT_W'(swept_ones);
    end

    assign sel_cnt = per_en && (per_addr == CTRL_WADDR + 14'd1);
    assign cnt_rd  = (sel_cnt && (per_we == 2'b00)) ? 16'(count_q) : 16'h0000;
`else
    assign cnt_rd = 16'h0000;
`endif

    assign per_dout   = (sel_ctrl && (per_we == 2'b00)) ? ctrl_rd : cnt_rd;
    assign dtable_out = dtable_q;

endmodule
